cgra_run_sequencer: RTL

//  Command-driven sequencer for the 2x2 mini-AIE tile array. Parses a byte stream
//  (from the top-level input pins), writes per-tile configuration memory, then runs
//  the array for a programmed number of compute steps, drains, and flags completion.

---
 rtl/cgra_pkg.sv | 21 ++
 rtl/cgra_run_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cgra_pkg.sv
// Shared types and constants for the mini-AIE run sequencer.
package cgra_pkg;

   localparam int unsigned NUM_TILES = 4;
   localparam int unsigned CFG_WORDS = 16;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRunArg,
      StRun,
      StDrain,
      StDone
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_ABORT = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

endpackage

// File: rtl/cgra_run_sequencer.sv
// Byte-command sequencer: loads per-tile config, runs the tile array for N steps,
// drains, then flags completion.
module cgra_run_sequencer #(
   parameter int unsigned NUM_TILES    = cgra_pkg::NUM_TILES,
   parameter int unsigned CFG_WORDS    = cgra_pkg::CFG_WORDS,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ena,
   input  logic                         cmd_valid,
   input  logic [7:0]                   cmd_data,
   output logic                         cmd_ready,
   output logic                         cfg_we,
   output logic [$clog2(NUM_TILES)-1:0] cfg_tile,
   output logic [$clog2(CFG_WORDS)-1:0] cfg_addr,
   output logic [7:0]                   cfg_wdata,
   output logic [NUM_TILES-1:0]         tile_en,
   output logic                         tile_step,
   output logic                         busy,
   output logic                         done,
   output logic                         err
);
   import cgra_pkg::*;

   localparam int unsigned TW     = $clog2(NUM_TILES);
   localparam int unsigned CFG_AW = $clog2(CFG_WORDS);

   state_e                state_q, state_d;
   logic [TW-1:0]         tile_q, tile_d;
   logic [CFG_AW-1:0]     addr_q, addr_d;
   logic [4:0]            rem_q, rem_d;
   logic [8:0]            cnt_q, cnt_d;
   logic [NUM_TILES-1:0]  loaded_q, loaded_d;
   logic                  cfg_we_q, cfg_we_d;
   logic [TW-1:0]         cfg_tile_q, cfg_tile_d;
   logic [CFG_AW-1:0]     cfg_addr_q, cfg_addr_d;
   logic [7:0]            cfg_wdata_q, cfg_wdata_d;
   logic [NUM_TILES-1:0]  tile_en_q, tile_en_d;
   logic                  tile_step_q, tile_step_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [1:0] op;
   assign op = cmd_data[7:6];

   always_comb begin
      state_d     = state_q;
      tile_d      = tile_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      loaded_d    = loaded_q;
      cfg_we_d    = cfg_we_q;
      cfg_tile_d  = cfg_tile_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_wdata_d = cfg_wdata_q;
      tile_en_d   = tile_en_q;
      tile_step_d = tile_step_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;
      // With ena low every register holds, so a pending write or step resumes intact.
      if (ena) begin
         cfg_we_d = 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (cmd_valid) begin
                  done_d  = 1'b0;
                  state_d = StIdle;
                  case (op)
                     OP_LOAD: begin
                        if (32'(cmd_data[5:4]) >= NUM_TILES) begin
                           err_d = 1'b1;
                        end else begin
                           state_d  = StLoad;
                           tile_d   = cmd_data[4 +: TW];
                           rem_d    = (cmd_data[3:0] == 4'd0) ? 5'd16 : {1'b0, cmd_data[3:0]};
                           addr_d   = '0;
                           loaded_d[cmd_data[4 +: TW]] = 1'b1;
                        end
                     end
                     OP_RUN:   state_d = StRunArg;
                     OP_CLEAR: begin
                        loaded_d = '0;
                        err_d    = 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            StLoad: begin
               if (cmd_valid) begin
                  cfg_we_d    = 1'b1;
                  cfg_tile_d  = tile_q;
                  cfg_addr_d  = addr_q;
                  cfg_wdata_d = cmd_data;
                  addr_d      = addr_q + CFG_AW'(1);
                  rem_d       = rem_q - 5'd1;
                  if (rem_q == 5'd1) state_d = StIdle;
               end
            end
            StRunArg: begin
               if (cmd_valid) begin
                  if (loaded_q == '0) begin
                     err_d   = 1'b1;
                     state_d = StIdle;
                  end else begin
                     cnt_d       = (cmd_data == 8'd0) ? 9'd256 : {1'b0, cmd_data};
                     state_d     = StRun;
                     tile_en_d   = loaded_q;
                     tile_step_d = 1'b1;
                  end
               end
            end
            StRun, StDrain: begin
               if (cmd_valid && op == OP_ABORT) begin
                  state_d     = StIdle;
                  tile_en_d   = '0;
                  tile_step_d = 1'b0;
               end else begin
                  if (cmd_valid) err_d = 1'b1;
                  // cnt_q counts remaining steps in RUN, remaining drain cycles in DRAIN.
                  if (cnt_q != 9'd1) begin
                     cnt_d = cnt_q - 9'd1;
                  end else if (state_q == StRun) begin
                     state_d     = StDrain;
                     tile_step_d = 1'b0;
                     cnt_d       = 9'(DRAIN_CYCLES);
                  end else begin
                     state_d   = StDone;
                     done_d    = 1'b1;
                     tile_en_d = '0;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
         busy_d = (state_d == StLoad) || (state_d == StRunArg) ||
                  (state_d == StRun)  || (state_d == StDrain);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         tile_q      <= '0;
         addr_q      <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         loaded_q    <= '0;
         cfg_we_q    <= 1'b0;
         cfg_tile_q  <= '0;
         cfg_addr_q  <= '0;
         cfg_wdata_q <= '0;
         tile_en_q   <= '0;
         tile_step_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         tile_q      <= tile_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         loaded_q    <= loaded_d;
         cfg_we_q    <= cfg_we_d;
         cfg_tile_q  <= cfg_tile_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_wdata_q <= cfg_wdata_d;
         tile_en_q   <= tile_en_d;
         tile_step_q <= tile_step_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cmd_ready = ena & ~rst;
   assign cfg_we    = cfg_we_q & ena;
   assign tile_step = tile_step_q & ena;
   assign cfg_tile  = cfg_tile_q;
   assign cfg_addr  = cfg_addr_q;
   assign cfg_wdata = cfg_wdata_q;
   assign tile_en   = tile_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
